// File: rtl/seg_scan_ctrl_if.sv
// Update handshake and digit data bundle for the seven-segment scanner.
// The producer drives the data and the request; the scanner returns the ack.
interface seg_scan_ctrl_if;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic        upd_req;
  logic        upd_ack;

  modport master (
    output din, dp_in, en_in, upd_req,
    input  upd_ack
  );

  modport slave (
    input  din, dp_in, en_in, upd_req,
    output upd_ack
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with dead-time,
// leading-zero blanking and frame-synchronous, tear-free updates.
module seg_scan_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int DEAD     = 16,
  parameter int LZB      = 1
) (
  input  logic           ck,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus,
  output logic [3:0]     an,
  output logic [6:0]     seg,
  output logic           dp,
  output logic           frame
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST    = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] SHOW_AT = CW'(DEAD - 1);

  typedef enum logic {
    DARK = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [1:0]  idx;
  logic [15:0] act_d;
  logic [3:0]  act_dp;
  logic [3:0]  act_en;
  logic [15:0] sh_d;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_en;
  logic        pend;
  logic        ack;

  logic        last;
  logic        bound;
  logic        z3;
  logic        z2;
  logic        z1;
  logic [3:0]  blank;
  logic [3:0]  nib;
  logic        lit;
  logic [6:0]  glyph;

  assign last  = (cnt == LAST);
  assign bound = last && (idx == 2'd3);
  assign frame = bound;
  assign bus.upd_ack = ack;

  // A digit is blanked only when it and every digit to its left are zero
  // with no decimal point requested.
  assign z3 = (act_d[15:12] == 4'd0) && !act_dp[3];
  assign z2 = z3 && (act_d[11:8] == 4'd0) && !act_dp[2];
  assign z1 = z2 && (act_d[7:4] == 4'd0) && !act_dp[1];
  assign blank = (LZB != 0) ? {z3, z2, z1, 1'b0} : 4'b0000;

  assign nib = act_d[{idx, 2'b00} +: 4];
  assign lit = (state == SHOW) && act_en[idx] && !blank[idx];

  always_comb begin
    glyph = 7'h7F;
    unique case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      state  <= DARK;
      cnt    <= '0;
      idx    <= 2'd0;
      act_d  <= 16'h0000;
      act_dp <= 4'b0000;
      act_en <= 4'b0000;
      sh_d   <= 16'h0000;
      sh_dp  <= 4'b0000;
      sh_en  <= 4'b0000;
      pend   <= 1'b0;
      ack    <= 1'b0;
      an     <= 4'hF;
      seg    <= 7'h7F;
      dp     <= 1'b1;
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        idx <= idx + 2'd1;
      end

      if (last) begin
        state <= DARK;
      end else if (cnt == SHOW_AT) begin
        state <= SHOW;
      end

      an  <= lit ? ~(4'b0001 << idx) : 4'hF;
      seg <= lit ? glyph : 7'h7F;
      dp  <= lit ? ~act_dp[idx] : 1'b1;

      // A request on the boundary itself bypasses the shadow copy.
      ack <= 1'b0;
      if (bound && (pend || bus.upd_req)) begin
        act_d  <= bus.upd_req ? bus.din   : sh_d;
        act_dp <= bus.upd_req ? bus.dp_in : sh_dp;
        act_en <= bus.upd_req ? bus.en_in : sh_en;
        pend   <= 1'b0;
        ack    <= 1'b1;
      end else if (bus.upd_req) begin
        sh_d  <= bus.din;
        sh_dp <= bus.dp_in;
        sh_en <= bus.en_in;
        pend  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl at TICK_DIV=8, DEAD=2, LZB=1.
// Stimulus queues per-frame digit expectations and ack times; a monitor checks them.
module tb_seg_scan_ctrl;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GX = 7'h7F;
  localparam logic [11:0] DARK_V = 12'hFFF;

  typedef struct {
    int          fnum;
    logic [3:0]  lit;
    logic [27:0] sg;
    logic [3:0]  dpl;
  } exp_t;

  logic       ck;
  logic       rst;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(
    .TICK_DIV(8),
    .DEAD    (2),
    .LZB     (1)
  ) dut (
    .ck   (ck),
    .rst  (rst),
    .bus  (bus),
    .an   (an),
    .seg  (seg),
    .dp   (dp),
    .frame(frame)
  );

  int   checks = 0;
  int   errors = 0;
  int   tc = 0;
  logic rst_smp = 1'b0;

  exp_t eq[$];
  int   aq[$];

  logic [3:0]  an_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [11:0] obs [4];
  bit          bad [4];
  bit          fbad = 1'b0;

  initial ck = 1'b0;
  always #5 ck = ~ck;

  always @(posedge ck) begin
    rst_smp = rst;
  end

  always @(posedge ck) begin
    tc <= rst ? tc + 1 : 0;
  end

  task automatic frame_done(int f);
    exp_t        e;
    logic [11:0] want;
    while (eq.size() > 0 && eq[0].fnum < f) begin
      checks++;
      errors++;
      $display("FAIL missed_frame: expectation for frame %0d never matched, now at frame %0d",
               eq[0].fnum, f);
      void'(eq.pop_front());
    end
    if (eq.size() > 0 && eq[0].fnum == f) begin
      e = eq.pop_front();
      for (int d = 0; d < 4; d++) begin
        want = e.lit[d] ? {an_sel[d], e.sg[7*d +: 7], ~e.dpl[d]} : DARK_V;
        checks++;
        if (bad[d] || obs[d] !== want) begin
          errors++;
          $display("FAIL digit%0d frame%0d: got {an,seg,dp}=%b unstable=%0d, required %b",
                   d, f, obs[d], bad[d], want);
        end
      end
    end
    for (int i = 0; i < 4; i++) bad[i] = 1'b0;
  endtask

  task automatic ack_seen(int at);
    int want;
    checks++;
    if (aq.size() == 0) begin
      errors++;
      $display("FAIL upd_ack: got pulse after cycle %0d, required none", at);
    end else begin
      want = 32 * aq.pop_front() + 31;
      if (at != want) begin
        errors++;
        $display("FAIL upd_ack: got pulse after cycle %0d, required after cycle %0d", at, want);
      end
    end
  endtask

  always @(negedge ck) begin
    logic [11:0] v;
    int u;
    int d;
    int c;
    v = {an, seg, dp};
    if (!rst_smp) begin
      for (int i = 0; i < 4; i++) begin
        bad[i] = 1'b0;
        obs[i] = DARK_V;
      end
      fbad = 1'b0;
    end else begin
      if (frame !== ((tc % 32) == 31)) fbad = 1'b1;
      if ((tc % 32) == 31) begin
        checks++;
        if (frame !== 1'b1 || fbad) begin
          errors++;
          $display("FAIL frame: cycle %0d got frame=%b stray=%0d, required frame=1 stray=0",
                   tc, frame, fbad);
        end
        fbad = 1'b0;
      end
      if (bus.upd_ack === 1'b1) ack_seen(tc - 1);
      if (tc >= 1) begin
        u = tc - 1;
        d = (u % 32) / 8;
        c = u % 8;
        if (c < 2) begin
          if (v !== DARK_V) bad[d] = 1'b1;
        end else if (c == 2) begin
          obs[d] = v;
        end else if (v !== obs[d]) begin
          bad[d] = 1'b1;
        end
        if ((u % 32) == 31) frame_done(u / 32);
      end
    end
  end

  task automatic chk(string name, logic [15:0] got, logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic push_exp(int f, logic [3:0] lit, logic [27:0] sg, logic [3:0] dpl);
    exp_t e;
    e.fnum = f;
    e.lit  = lit;
    e.sg   = sg;
    e.dpl  = dpl;
    eq.push_back(e);
  endtask

  task automatic goto(int n);
    int g = 0;
    while (tc != n && g < 3000) begin
      @(posedge ck);
      #1;
      g++;
    end
    if (tc != n) begin
      checks++;
      errors++;
      $display("FAIL goto: got cycle %0d, required %0d", tc, n);
    end
  endtask

  task automatic req(int n, logic [15:0] d, logic [3:0] p, logic [3:0] e);
    goto(n);
    bus.din     = d;
    bus.dp_in   = p;
    bus.en_in   = e;
    bus.upd_req = 1'b1;
    @(posedge ck);
    #1;
    bus.upd_req = 1'b0;
  endtask

  task automatic do_reset(int ncyc);
    rst = 1'b0;
    @(posedge ck);
    @(negedge ck);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_ack", 16'(bus.upd_ack), 16'h0);
    chk("rst_frame", 16'(frame), 16'h0);
    repeat (ncyc - 1) @(posedge ck);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    bus.din     = 16'h0000;
    bus.dp_in   = 4'b0000;
    bus.en_in   = 4'b0000;
    bus.upd_req = 1'b0;

    do_reset(3);
    push_exp(0, 4'b0000, {4{GX}}, 4'b0000);

    req(5, 16'h1234, 4'b0000, 4'b1111);
    aq.push_back(0);
    push_exp(1, 4'b1111, {G1, G2, G3, G4}, 4'b0000);

    req(40, 16'h0070, 4'b0000, 4'b1111);
    aq.push_back(1);
    push_exp(2, 4'b0011, {GX, GX, G7, G0}, 4'b0000);

    req(70, 16'h0070, 4'b0100, 4'b1111);
    aq.push_back(2);
    push_exp(3, 4'b0111, {GX, G0, G7, G0}, 4'b0100);

    req(100, 16'h1111, 4'b0000, 4'b1111);
    req(110, 16'h2222, 4'b0000, 4'b1111);
    aq.push_back(3);
    push_exp(4, 4'b1111, {G2, G2, G2, G2}, 4'b0000);

    req(159, 16'h8888, 4'b0000, 4'b1111);
    aq.push_back(4);
    push_exp(5, 4'b1111, {G8, G8, G8, G8}, 4'b0000);

    req(170, 16'h0000, 4'b0000, 4'b1111);
    aq.push_back(5);
    push_exp(6, 4'b0001, {GX, GX, GX, G0}, 4'b0000);

    req(200, 16'hABCD, 4'b0010, 4'b1010);
    aq.push_back(6);
    push_exp(7, 4'b1010, {GA, GX, GC, GX}, 4'b0010);

    req(260, 16'h5555, 4'b0000, 4'b1111);
    goto(268);
    do_reset(3);
    push_exp(0, 4'b0000, {4{GX}}, 4'b0000);

    req(40, 16'h8888, 4'b0000, 4'b1111);
    goto(63);
    do_reset(1);
    push_exp(0, 4'b0000, {4{GX}}, 4'b0000);
    push_exp(1, 4'b0000, {4{GX}}, 4'b0000);

    goto(70);
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL leftover_frames: got %0d unmatched, required 0", eq.size());
    end
    checks++;
    if (aq.size() != 0) begin
      errors++;
      $display("FAIL leftover_acks: got %0d missing acks, required 0", aq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
